// File: rtl/if_fetch_unit.sv
`default_nettype none
// ==========================================================================
// if_fetch_unit : instruction fetch stage with PC, imem req/ack, 1-entry skid, redirect
// Revision 1.0
// ==========================================================================
module if_fetch_unit #(
   parameter int                     ADDRESS_LEN     = 32,
   parameter int                     INSTRUCTION_LEN = 32,
   parameter logic [ADDRESS_LEN-1:0] RESET_PC        = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall,
   input  logic                       redirect_valid,
   input  logic [ADDRESS_LEN-1:0]     redirect_pc,
   output logic                       imem_req,
   output logic [ADDRESS_LEN-1:0]     imem_addr,
   input  logic                       imem_ack,
   input  logic [INSTRUCTION_LEN-1:0] imem_rdata,
   output logic                       fetch_valid,
   output logic [ADDRESS_LEN-1:0]     fetch_pc,
   output logic [INSTRUCTION_LEN-1:0] fetch_instruction
);

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_SKID    = 2'd1,
      ST_DISCARD = 2'd2
   } state_t;

   localparam logic [ADDRESS_LEN-1:0] c_pc_step = ADDRESS_LEN'(4);

   state_t                     r_state;
   logic                       r_req;
   logic [ADDRESS_LEN-1:0]     r_pc;
   logic [ADDRESS_LEN-1:0]     r_pending;
   logic [ADDRESS_LEN-1:0]     r_skid_pc;
   logic [INSTRUCTION_LEN-1:0] r_skid_instr;
   logic                       r_fetch_valid;
   logic [ADDRESS_LEN-1:0]     r_fetch_pc;
   logic [INSTRUCTION_LEN-1:0] r_fetch_instr;

   logic                       w_slot_free;
   logic                       w_consumed;
   logic [ADDRESS_LEN-1:0]     w_pc_next;
   logic [ADDRESS_LEN-1:0]     w_target;
   logic                       w_unused_bits;

   assign w_slot_free   = !r_fetch_valid || !stall;
   assign w_consumed    = r_fetch_valid && !stall;
   assign w_pc_next     = r_pc + c_pc_step;
   assign w_target      = {redirect_pc[ADDRESS_LEN-1:2], 2'b00};
   assign w_unused_bits = &{1'b0, redirect_pc[1:0]};

   // Request drops combinationally under reset so an in-flight access is abandoned.
   assign imem_req          = r_req && !rst;
   assign imem_addr         = r_pc;
   assign fetch_valid       = r_fetch_valid;
   assign fetch_pc          = r_fetch_pc;
   assign fetch_instruction = r_fetch_instr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_FETCH;
         r_req         <= 1'b1;
         r_pc          <= RESET_PC;
         r_pending     <= '0;
         r_skid_pc     <= '0;
         r_skid_instr  <= '0;
         r_fetch_valid <= 1'b0;
         r_fetch_pc    <= '0;
         r_fetch_instr <= '0;
      end else if (redirect_valid) begin
         // Flush wins over stall, ack and skid; the skid entry is abandoned.
         r_fetch_valid <= 1'b0;
         r_req         <= 1'b1;
         case (r_state)
            ST_FETCH: begin
               if (imem_ack) begin
                  r_pc <= w_target;
               end else begin
                  r_pending <= w_target;
                  r_state   <= ST_DISCARD;
               end
            end
            ST_SKID: begin
               r_pc    <= w_target;
               r_state <= ST_FETCH;
            end
            ST_DISCARD: begin
               if (imem_ack) begin
                  r_pc    <= w_target;
                  r_state <= ST_FETCH;
               end else begin
                  r_pending <= w_target;
               end
            end
            default: begin
               r_pc    <= w_target;
               r_state <= ST_FETCH;
            end
         endcase
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (imem_ack) begin
                  r_pc <= w_pc_next;
                  if (w_slot_free) begin
                     r_fetch_valid <= 1'b1;
                     r_fetch_pc    <= w_pc_next;
                     r_fetch_instr <= imem_rdata;
                  end else begin
                     r_skid_pc    <= w_pc_next;
                     r_skid_instr <= imem_rdata;
                     r_req        <= 1'b0;
                     r_state      <= ST_SKID;
                  end
               end else if (w_consumed) begin
                  r_fetch_valid <= 1'b0;
               end
            end
            ST_SKID: begin
               if (w_slot_free) begin
                  r_fetch_valid <= 1'b1;
                  r_fetch_pc    <= r_skid_pc;
                  r_fetch_instr <= r_skid_instr;
                  r_req         <= 1'b1;
                  r_state       <= ST_FETCH;
               end
            end
            ST_DISCARD: begin
               // The returning word belongs to the flushed path and is dropped.
               if (imem_ack) begin
                  r_pc    <= r_pending;
                  r_state <= ST_FETCH;
               end
            end
            default: begin
               r_req   <= 1'b1;
               r_state <= ST_FETCH;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ==========================================================================
// tb_if_fetch_unit : directed table-driven bench for if_fetch_unit
// Revision 1.0
// ==========================================================================
module tb_if_fetch_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_instruction;

   int total;
   int bad;

   if_fetch_unit #(
      .ADDRESS_LEN     (32),
      .INSTRUCTION_LEN (32),
      .RESET_PC        (32'h0)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .stall             (stall),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_ack          (imem_ack),
      .imem_rdata        (imem_rdata),
      .fetch_valid       (fetch_valid),
      .fetch_pc          (fetch_pc),
      .fetch_instruction (fetch_instruction)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        ack;
      logic [31:0] rdata;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_ins;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic r, input logic s, input logic rd,
                               input logic [31:0] rpc, input logic a,
                               input logic [31:0] d, input logic eq,
                               input logic [31:0] ea, input logic ev,
                               input logic [31:0] ep, input logic [31:0] ei);
      vec_t v;
      v.rst = r; v.stall = s; v.redir = rd; v.rpc = rpc; v.ack = a; v.rdata = d;
      v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_ins = ei;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      rst            = v.rst;
      stall          = v.stall;
      redirect_valid = v.redir;
      redirect_pc    = v.rpc;
      imem_ack       = v.ack;
      imem_rdata     = v.rdata;
      @(posedge clk);
      #1;
      chk("imem_req", idx, {31'b0, imem_req}, {31'b0, v.e_req});
      chk("imem_addr", idx, imem_addr, v.e_addr);
      chk("fetch_valid", idx, {31'b0, fetch_valid}, {31'b0, v.e_valid});
      if (v.e_valid || v.rst) begin
         chk("fetch_pc", idx, fetch_pc, v.e_pc);
         chk("fetch_instruction", idx, fetch_instruction, v.e_ins);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst            = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_ack       = 1'b0;
      imem_rdata     = '0;

      //                rst stl rdr rpc            ack data          req addr           vld pc             ins
      // reset
      vq.push_back(mk(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0));
      vq.push_back(mk(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0));
      // zero-wait streaming
      vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'h11110000,  1, 32'h4,         1, 32'h4,         32'h11110000));
      vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'h22220000,  1, 32'h8,         1, 32'h8,         32'h22220000));
      vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'h33330000,  1, 32'hC,         1, 32'hC,         32'h33330000));
      vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'h44440000,  1, 32'h10,        1, 32'h10,        32'h44440000));
      // 3-cycle latency at 0x10
      vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h10,        0, 32'h0,         32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h10,        0, 32'h0,         32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h10,        0, 32'h0,         32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'h55550000,  1, 32'h14,        1, 32'h14,        32'h55550000));
      vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'h66660000,  1, 32'h18,        1, 32'h18,        32'h66660000));
      vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'h77770000,  1, 32'h1C,        1, 32'h1C,        32'h77770000));
      vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'h88880000,  1, 32'h20,        1, 32'h20,        32'h88880000));
      // stall for 4 cycles while 0x20 returns
      vq.push_back(mk(0, 1, 0, 32'h0,         1, 32'hAABBCCDD,  0, 32'h24,        1, 32'h20,        32'h88880000));
      vq.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h24,        1, 32'h20,        32'h88880000));
      vq.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h24,        1, 32'h20,        32'h88880000));
      vq.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h24,        1, 32'h20,        32'h88880000));
      vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h24,        1, 32'h24,        32'hAABBCCDD));
      vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h24,        0, 32'h0,         32'h0));
      // redirect with ack in FETCH, then redirect to 0x103 while 0x40 is outstanding
      vq.push_back(mk(0, 0, 1, 32'h40,        1, 32'hDEAD0024,  1, 32'h40,        0, 32'h0,         32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h40,        0, 32'h0,         32'h0));
      vq.push_back(mk(0, 0, 1, 32'h103,       0, 32'h0,         1, 32'h40,        0, 32'h0,         32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h40,        0, 32'h0,         32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'hBADBAD40,  1, 32'h100,       0, 32'h0,         32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'h01000100,  1, 32'h104,       1, 32'h104,       32'h01000100));
      // redirect + stall + ack together
      vq.push_back(mk(0, 1, 1, 32'h200,       1, 32'hBAD00104,  1, 32'h200,       0, 32'h0,         32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'h02000200,  1, 32'h204,       1, 32'h204,       32'h02000200));
      // newest redirect wins in DISCARD, ack in same cycle
      vq.push_back(mk(0, 0, 1, 32'h300,       0, 32'h0,         1, 32'h204,       0, 32'h0,         32'h0));
      vq.push_back(mk(0, 0, 1, 32'h400,       1, 32'hBAD00204,  1, 32'h400,       0, 32'h0,         32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'h04000400,  1, 32'h404,       1, 32'h404,       32'h04000400));
      // PC wrap
      vq.push_back(mk(0, 0, 1, 32'hFFFFFFFE,  1, 32'hBAD00404,  1, 32'hFFFFFFFC,  0, 32'h0,         32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'hFFFF0000,  1, 32'h0,         1, 32'h0,         32'hFFFF0000));
      // reset while waiting with a held output
      vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'h12345678,  1, 32'h4,         1, 32'h4,         32'h12345678));
      vq.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h4,         1, 32'h4,         32'h12345678));
      vq.push_back(mk(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'hCAFE0000,  1, 32'h4,         1, 32'h4,         32'hCAFE0000));

      foreach (vq[i]) apply(vq[i], i);

      // Redirect while parked in SKID: skid entry must never surface.
      apply(mk(0, 1, 0, 32'h0,   1, 32'h5EED0004, 0, 32'h8,   1, 32'h4,   32'hCAFE0000), 100);
      apply(mk(0, 1, 1, 32'h500, 0, 32'h0,        1, 32'h500, 0, 32'h0,   32'h0),        101);
      apply(mk(0, 1, 0, 32'h0,   1, 32'h05000500, 1, 32'h504, 1, 32'h504, 32'h05000500), 102);
      apply(mk(0, 0, 0, 32'h0,   0, 32'h0,        1, 32'h504, 0, 32'h0,   32'h0),        103);

      // Variable-latency request: memory answers 5 cycles after seeing req, bounded wait.
      begin
         int waited;
         waited = 0;
         @(negedge clk);
         imem_ack = 1'b0;
         while (!imem_req && waited < 20) begin
            @(negedge clk);
            waited++;
         end
         total++;
         if (!imem_req) begin
            bad++;
            $display("FAIL req_timeout: got imem_req=0 expected 1 within 20 cycles");
         end
      end
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         chk("hold_req", 200 + k, {31'b0, imem_req}, 32'h1);
         chk("hold_addr", 200 + k, imem_addr, 32'h504);
      end
      apply(mk(0, 0, 0, 32'h0, 1, 32'h05040504, 1, 32'h508, 1, 32'h508, 32'h05040504), 210);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
